event_sequencer: RTL

Programmable event-pulse sequencer. It holds a queue of (event id, relative delay) entries, then on `start` replays them as one-cycle pulses on a per-event strobe bus. Each pulse is spaced from the previous one by its programmed delay. It sits between a configuration master and any blocks that wait on named strobes, acting as the synthesizable scheduler for the event-triggering timelines the team uses in benches and as a sequencing controller in RTL.

---
 rtl/event_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/event_sequencer.sv
// Queues (event id, delay) entries and replays them as one-cycle strobes; first pulse d0+2 cycles after start.
// Writes are accepted only while idle and not full; all other writes are dropped, not stalled.
module event_sequencer #(
    parameter int NUM_EVENTS = 4,
    parameter int DEPTH      = 8,
    parameter int DLY_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [$clog2(NUM_EVENTS)-1:0] wr_id,
    input  logic [DLY_W-1:0]              wr_delay,
    input  logic                          start,
    input  logic                          abort,
    output logic [NUM_EVENTS-1:0]         ev_pulse,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic [$clog2(DEPTH+1)-1:0]    fired
);

    localparam int ID_W  = $clog2(NUM_EVENTS);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int DEC_W = 1 << ID_W;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   q_id  [DEPTH];
    logic [DLY_W-1:0]  q_dly [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [LVL_W-1:0]  count;
    logic [DLY_W-1:0]  cnt;
    logic [ID_W-1:0]   cur_id;
    logic              armed;
    logic              push, pop, fire, clr_fired;
    logic [DEC_W-1:0]  dec;

    assign wr_ready = (state == IDLE) && (count != LVL_W'(DEPTH));
    assign push     = wr_valid && wr_ready && !abort;
    assign busy     = (state != IDLE);
    assign done     = (state == FIN) && !abort;
    assign level    = count;

    // Ids beyond NUM_EVENTS land in the truncated decode bits and strobe nothing.
    always_comb begin
        dec         = '0;
        dec[cur_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // armed means cnt holds an entry still to fire; RUN with nothing armed drains to FIN.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        fire      = 1'b0;
        clr_fired = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        clr_fired = 1'b1;
                        if (count != '0) begin
                            pop       = 1'b1;
                            state_nxt = RUN;
                        end else begin
                            state_nxt = FIN;
                        end
                    end
                end
                RUN: begin
                    if (!armed) begin
                        state_nxt = FIN;
                    end else if (cnt == '0) begin
                        fire = 1'b1;
                        pop  = (count != '0);
                    end
                end
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr]  <= wr_id;
            q_dly[wr_ptr] <= wr_delay;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            cnt      <= '0;
            cur_id   <= '0;
            armed    <= 1'b0;
            ev_pulse <= '0;
            fired    <= '0;
            aborted  <= 1'b0;
        end else begin
            aborted <= abort && (state != IDLE);
            if (abort) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                cnt      <= '0;
                armed    <= 1'b0;
                ev_pulse <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                ev_pulse <= fire ? dec[NUM_EVENTS-1:0] : '0;
                if (pop) begin
                    cnt    <= q_dly[rd_ptr];
                    cur_id <= q_id[rd_ptr];
                    armed  <= 1'b1;
                end else if (fire) begin
                    armed <= 1'b0;
                end else if (state == RUN && cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end
                if (clr_fired)  fired <= '0;
                else if (fire)  fired <= fired + 1'b1;
            end
        end
    end

endmodule
